// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//   Tracks up to two in-flight branch predictions issued from ID. When EX
//   resolves the oldest one, it compares against the prediction. On a
//   mispredict, it drives a one-cycle redirect with both flushes, then one
//   cycle flushing only IF/ID.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               freezes FIFO, FSM and counters
//   pred_*              prediction push {taken, pc, target}
//   resolve_*           resolution of the oldest in-flight prediction
//   redirect_valid/pc   fetch redirect (pulse, held while stalled)
//   flush_if_id/id_ex   pipeline register invalidates
//   tracker_full        FIFO holds two entries
//   branch_cnt          saturating count of resolutions
//   mispredict_cnt      saturating count of mispredicts
//   overflow_err        sticky: push dropped because the FIFO was full
//   underflow_err       sticky: resolve seen with the FIFO empty
//   dbg_state           current FSM state (0 IDLE, 1 REDIRECT, 2 FLUSH)
//
// Handshake: a push or pop happens in the cycle its valid is high, the FSM
// is IDLE and stall is low. There is no ready signal. A push is dropped when
// the FIFO is full, unless a pop happens in the same cycle. A pop is ignored
// when the FIFO is empty.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        pred_valid,
   input  logic        pred_taken,
   input  logic [31:0] pred_pc,
   input  logic [31:0] pred_target,
   input  logic        resolve_valid,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        tracker_full,
   output logic [15:0] branch_cnt,
   output logic [15:0] mispredict_cnt,
   output logic        overflow_err,
   output logic        underflow_err,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_REDIRECT = 2'd1;
   localparam logic [1:0] S_FLUSH    = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       r_ent_taken;
   logic [1:0][31:0] r_ent_pc;
   logic [1:0][31:0] r_ent_tgt;
   logic             r_head;
   logic [1:0]       r_count;
   logic [31:0]      r_redirect_pc;
   logic [15:0]      r_branch_cnt;
   logic [15:0]      r_mis_cnt;
   logic             r_ovf;
   logic             r_unf;

   logic        w_idle;
   logic        w_push_req;
   logic        w_pop_req;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push;
   logic        w_wr_idx;
   logic        w_head_taken;
   logic [31:0] w_head_pc;
   logic [31:0] w_head_tgt;
   logic        w_mispredict;
   logic [31:0] w_correct_pc;

   assign w_idle     = (r_state == S_IDLE);
   assign w_push_req = pred_valid & ~stall & w_idle;
   assign w_pop_req  = resolve_valid & ~stall & w_idle;
   assign w_empty    = (r_count == 2'd0);
   assign w_full     = (r_count == 2'd2);
   assign w_pop      = w_pop_req & ~w_empty;
   // When the FIFO is full, a push is accepted only if the head leaves
   // in the same cycle.
   assign w_push     = w_push_req & (~w_full | w_pop);
   // The tail slot is head+count mod 2. When the FIFO is full, this is the
   // head slot. The head is read before the edge overwrites it.
   assign w_wr_idx   = r_head ^ r_count[0];

   assign w_head_taken = r_ent_taken[r_head];
   assign w_head_pc    = r_ent_pc[r_head];
   assign w_head_tgt   = r_ent_tgt[r_head];

   assign w_mispredict = (w_head_taken != resolve_taken) |
                         (w_head_taken & resolve_taken & (w_head_tgt != resolve_target));
   assign w_correct_pc = resolve_taken ? resolve_target : (w_head_pc + 32'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_ent_taken   <= '0;
         r_ent_pc      <= '0;
         r_ent_tgt     <= '0;
         r_head        <= 1'b0;
         r_count       <= 2'd0;
         r_redirect_pc <= 32'h0;
         r_branch_cnt  <= 16'h0;
         r_mis_cnt     <= 16'h0;
         r_ovf         <= 1'b0;
         r_unf         <= 1'b0;
      end else if (!stall) begin
         case (r_state)
            S_IDLE: begin
               if (w_pop && r_branch_cnt != 16'hFFFF)
                  r_branch_cnt <= r_branch_cnt + 16'd1;
               if (w_pop && w_mispredict && r_mis_cnt != 16'hFFFF)
                  r_mis_cnt <= r_mis_cnt + 16'd1;
               if (w_pop_req && w_empty)
                  r_unf <= 1'b1;
               if (w_push_req && w_full && !w_pop)
                  r_ovf <= 1'b1;

               if (w_pop && w_mispredict) begin
                  // Everything younger is wrong-path. Drop the whole FIFO,
                  // including a push arriving on this edge.
                  r_state       <= S_REDIRECT;
                  r_count       <= 2'd0;
                  r_head        <= 1'b0;
                  r_redirect_pc <= w_correct_pc;
               end else begin
                  if (w_push) begin
                     r_ent_taken[w_wr_idx] <= pred_taken;
                     r_ent_pc[w_wr_idx]    <= pred_pc;
                     r_ent_tgt[w_wr_idx]   <= pred_target;
                  end
                  if (w_pop)
                     r_head <= ~r_head;
                  r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
               end
            end
            S_REDIRECT: r_state <= S_FLUSH;
            S_FLUSH:    r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   assign redirect_valid = (r_state == S_REDIRECT);
   assign flush_if_id    = (r_state == S_REDIRECT) | (r_state == S_FLUSH);
   assign flush_id_ex    = (r_state == S_REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign tracker_full   = w_full;
   assign branch_cnt     = r_branch_cnt;
   assign mispredict_cnt = r_mis_cnt;
   assign overflow_err   = r_ovf;
   assign underflow_err  = r_unf;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//   Drives branch_redirect_ctrl with directed sequences and random traffic.
//   A behavioural model holds the prediction FIFO, state and counters. Each
//   expected redirect PC is queued in exp_q when its mispredicting resolve
//   is driven. The entry is popped and compared when the DUT raises
//   redirect_valid.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

   localparam logic [1:0] M_IDLE     = 2'd0;
   localparam logic [1:0] M_REDIRECT = 2'd1;
   localparam logic [1:0] M_FLUSH    = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        stall = 0, pred_valid = 0, pred_taken = 0;
   logic [31:0] pred_pc = 0, pred_target = 0;
   logic        resolve_valid = 0, resolve_taken = 0;
   logic [31:0] resolve_target = 0;
   logic        redirect_valid, flush_if_id, flush_id_ex, tracker_full;
   logic [31:0] redirect_pc;
   logic [15:0] branch_cnt, mispredict_cnt;
   logic        overflow_err, underflow_err;
   logic [1:0]  dbg_state;

   branch_redirect_ctrl dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_pc(pred_pc), .pred_target(pred_target),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .tracker_full(tracker_full), .branch_cnt(branch_cnt),
      .mispredict_cnt(mispredict_cnt), .overflow_err(overflow_err),
      .underflow_err(underflow_err), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard / model ----------------
   typedef struct packed {
      logic        t;
      logic [31:0] pc;
      logic [31:0] tgt;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] exp_q[$];
   logic [1:0]  m_state;
   int          m_bc, m_mc;
   bit          m_ovf, m_unf;
   logic [31:0] m_rpc;
   bit          prev_rv;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_state = M_IDLE;
      m_bc = 0; m_mc = 0;
      m_ovf = 0; m_unf = 0;
      m_rpc = 32'h0;
      prev_rv = 0;
   endtask

   // Advance the model using the inputs present at the coming rising edge.
   task automatic model_edge();
      ent_t        h, e;
      bit          mis;
      logic [31:0] cpc;
      if (stall) return;
      case (m_state)
         M_IDLE: begin
            mis = 0;
            if (resolve_valid && m_q.size() == 0) m_unf = 1;
            if (resolve_valid && m_q.size() != 0) begin
               h   = m_q[0];
               mis = (h.t != resolve_taken) || (h.t && resolve_taken && h.tgt != resolve_target);
               cpc = resolve_taken ? resolve_target : h.pc + 32'd4;
               if (m_bc < 16'hFFFF) m_bc++;
               if (mis && m_mc < 16'hFFFF) m_mc++;
            end
            if (mis) begin
               m_q.delete();
               m_state = M_REDIRECT;
               m_rpc   = cpc;
               exp_q.push_back(cpc);
            end else begin
               if (resolve_valid && m_q.size() != 0) void'(m_q.pop_front());
               if (pred_valid) begin
                  if (m_q.size() < 2) begin
                     e.t = pred_taken; e.pc = pred_pc; e.tgt = pred_target;
                     m_q.push_back(e);
                  end else m_ovf = 1;
               end
            end
         end
         M_REDIRECT: m_state = M_FLUSH;
         default:    m_state = M_IDLE;
      endcase
   endtask

   task automatic check_outputs();
      chk("state",         dbg_state,      m_state);
      chk("redirect_valid", redirect_valid, m_state == M_REDIRECT);
      chk("flush_if_id",   flush_if_id,    m_state != M_IDLE);
      chk("flush_id_ex",   flush_id_ex,    m_state == M_REDIRECT);
      chk("redirect_pc",   redirect_pc,    m_rpc);
      chk("tracker_full",  tracker_full,   m_q.size() == 2);
      chk("branch_cnt",    branch_cnt,     m_bc);
      chk("mispredict_cnt", mispredict_cnt, m_mc);
      chk("overflow_err",  overflow_err,   m_ovf);
      chk("underflow_err", underflow_err,  m_unf);
      // Scoreboard: consume one expected PC on each rising redirect.
      if (redirect_valid && !prev_rv) begin
         chk("sb_has_entry", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) chk("sb_redirect_pc", redirect_pc, exp_q.pop_front());
      end
      prev_rv = redirect_valid;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit pv, input bit pt, input logic [31:0] ppc, input logic [31:0] ptg,
                       input bit rv, input bit rt, input logic [31:0] rtg, input bit st);
      @(negedge clk);
      pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
      resolve_valid = rv; resolve_taken = rt; resolve_target = rtg; stall = st;
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input bit pt, input logic [31:0] ppc, input logic [31:0] ptg);
      step(1, pt, ppc, ptg, 0, 0, 0, 0);
   endtask

   task automatic resolve(input bit rt, input logic [31:0] rtg);
      step(0, 0, 0, 0, 1, rt, rtg, 0);
   endtask

   // Assert reset now, check outputs clear without a clock edge, and release
   // just after a rising edge so the next edge is the first active one.
   task automatic do_reset();
      pred_valid = 0; resolve_valid = 0; stall = 0;
      rst_n = 0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #2 rst_n = 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      do_reset();

      // First edge after release: push honoured, then a correct not-taken.
      push(0, 32'h100, 32'h0);
      resolve(0, 32'h0);
      idle(1);

      // Direction mispredict.
      push(0, 32'h200, 32'h0);
      resolve(1, 32'h300);
      idle(3);

      // Predicted taken, actually not taken.
      push(1, 32'h400, 32'h408);
      resolve(0, 32'h0);
      idle(3);

      // Taken with a matching target, then taken with a wrong target.
      push(1, 32'h500, 32'h600);
      resolve(1, 32'h600);
      push(1, 32'h700, 32'h800);
      resolve(1, 32'h900);
      idle(3);

      // pc+4 wraps at the top of the address space.
      push(1, 32'hFFFF_FFFC, 32'h10);
      resolve(0, 32'h0);
      idle(3);

      // Full, overflow, and push+pop while full.
      push(0, 32'hA00, 32'h0);
      push(0, 32'hB00, 32'h0);
      push(0, 32'hC00, 32'h0);
      step(1, 0, 32'hD00, 32'h0, 1, 0, 32'h0, 0);
      resolve(0, 32'h0);
      resolve(0, 32'h0);

      // Resolve while empty.
      resolve(1, 32'h44);

      // A mispredict in the same cycle as a push: the push is discarded.
      push(0, 32'hE00, 32'h0);
      step(1, 1, 32'hE10, 32'hE20, 1, 1, 32'hE40, 0);
      // Stall held during REDIRECT; pred/resolve are also ignored.
      for (int i = 0; i < 3; i++) step(1, 0, 32'hF00, 0, 1, 1, 32'h4, 1);
      idle(3);

      // Reset in the middle of FLUSH.
      push(0, 32'h1200, 32'h0);
      resolve(1, 32'h1300);
      idle(1);
      do_reset();
      idle(3);

      // Random traffic over a small address set, so targets often match.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 1), $urandom_range(0, 1),
              32'h1000 + 32'($urandom_range(0, 3)) * 32'h10,
              32'h2000 + 32'($urandom_range(0, 1)) * 32'h10,
              $urandom_range(0, 1), $urandom_range(0, 1),
              32'h2000 + 32'($urandom_range(0, 1)) * 32'h10,
              $urandom_range(0, 3) == 0);
      end
      idle(3);

      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL expose: clk  input  1  single clock, all state on rising edge.
REQ-002 The block SHALL expose: rst_n  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL expose: stall  input  1  pipeline freeze; no push, pop or FSM advance while 1.
REQ-004 The block SHALL expose: pred_valid  input  1  ID-stage predictor issued a prediction this cycle.
REQ-005 The block SHALL expose: pred_taken  input  1  predicted direction.
REQ-006 The block SHALL expose: pred_pc  input  32  PC of the predicted control-transfer instruction.
REQ-007 The block SHALL expose: pred_target  input  32  predicted next PC; don't-care when pred_taken=0.
REQ-008 The block SHALL expose: resolve_valid  input  1  EX stage resolved the oldest branch/JAL/JALR.
REQ-009 The block SHALL expose: resolve_taken  input  1  actual direction (br_en, or 1 for jumps).
REQ-010 The block SHALL expose: resolve_target  input  32  actual taken target.
REQ-011 The block SHALL expose: redirect_valid  output  1  one-cycle pulse; fetch loads redirect_pc.
REQ-012 The block SHALL expose: redirect_pc  output  32  corrected fetch PC.
REQ-013 The block SHALL expose: flush_if_id, flush_id_ex  output  1 each  invalidate those pipeline registers.
REQ-014 The block SHALL expose: tracker_full  output  1  in-flight prediction queue holds 2 entries.
REQ-015 The block SHALL expose: branch_cnt, mispredict_cnt  output  16 each  saturating performance counters.
REQ-016 The block SHALL expose: overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-017 The block SHALL hold in-flight predictions in a 2-entry FIFO of {taken, pc, target}, oldest at head.
REQ-018 Push SHALL occur when pred_valid=1, stall=0, FSM=IDLE and FIFO not full; pop SHALL occur when resolve_valid=1, stall=0, FSM=IDLE and FIFO not empty.
REQ-019 Simultaneous push and pop on a full FIFO SHALL both succeed; occupancy unchanged; the pop compares the pre-push head.
REQ-020 Push while full (and no pop) SHALL be dropped and set overflow_err; pop while empty SHALL be ignored (no counter change) and set underflow_err.
REQ-021 Mispredict SHALL be: head.taken != resolve_taken, or both taken and head.target != resolve_target.
REQ-022 Correct PC SHALL be resolve_target if resolve_taken=1, else head.pc + 4 (32-bit, wrapping modulo 2^32).
REQ-023 Every valid pop SHALL increment branch_cnt; every mispredicting pop SHALL also increment mispredict_cnt; both SHALL saturate at 16'hFFFF.
REQ-024 FSM states SHALL be IDLE, REDIRECT, FLUSH.
REQ-025 IDLE -> REDIRECT on the edge of a mispredicting pop; the FIFO SHALL be cleared on the same edge, discarding any simultaneous push.
REQ-026 In REDIRECT (exactly 1 cycle), redirect_valid=1, redirect_pc=captured correct PC, flush_if_id=1 and flush_id_ex=1; next state FLUSH.
REQ-027 In FLUSH (exactly 1 cycle), flush_if_id=1, flush_id_ex=0, redirect_valid=0; next state IDLE.
REQ-028 pred_valid and resolve_valid SHALL be ignored in REDIRECT and FLUSH (wrong-path).
REQ-029 stall=1 SHALL freeze FSM, FIFO and counters; outputs SHALL hold their current values.
REQ-030 All outputs SHALL be driven from registers or FSM-state decode only, never combinationally from inputs.
REQ-031 tracker_full SHALL equal (occupancy == 2).

Reset
REQ-032 rst_n=0 SHALL immediately force FSM=IDLE, FIFO empty, redirect_valid=0, redirect_pc=32'h0, both flushes=0, tracker_full=0, both counters=0, both error flags=0.
REQ-033 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abort the sequence; no further redirect or flush pulse after release.
REQ-034 The first push or pop SHALL be honoured on the first rising edge with rst_n=1.

Verification
REQ-035 Correct not-taken: push {0, 0x100, -}, resolve_taken=0 -> no redirect, branch_cnt=1, mispredict_cnt=0.
REQ-036 Direction mispredict: push {0, 0x200, -}, resolve {1, 0x300} -> next cycle redirect_valid=1, redirect_pc=0x300, both flushes=1; following cycle flush_if_id only; then IDLE, FIFO empty, mispredict_cnt=1.
REQ-037 Predicted taken, actually not taken: push {1, 0x400, 0x408}, resolve_taken=0 -> redirect_pc=0x404.
REQ-038 Full/overflow: two pushes -> tracker_full=1; third push -> dropped, overflow_err=1; simultaneous push+pop when full -> occupancy stays 2.
REQ-039 Empty resolve, stall, and reset: resolve with FIFO empty -> underflow_err=1, counters unchanged; stall=1 during REDIRECT holds redirect_valid=1 until stall drops; rst_n=0 during FLUSH -> all outputs 0 immediately.
